// File: rtl/spu_datapath_pipe.sv
// rtl/spu_datapath_pipe.sv - two-stage SPU datapath: register file, 8-op ALU, write-back mux, EX/WB stage
//
// Optional feature macro: SPU_DP_BYPASS_EN
//   defined   : stage data forwarded to rp/rq operands, never stalls (hazard=0, in_ready=1)
//   undefined : RAW conflict with the pending write raises hazard and stalls issue one cycle
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   op handshake from the controller; issue = in_valid & in_ready
//   rp_addr, rq_addr      operand read addresses
//   w_addr, w_en          destination register and write enable
//   wb_sel                0=ALU 1=dm_r_data 2=imm 3=zero
//   alu_op                0 pass,1 add,2 sub,3 and,4 or,5 xor,6 shl,7 shr
//   imm, imm_sext         immediate and its extension mode
//   dm_r_data             memory read data (issue cycle)
//   dm_w_data, rp_zero    rp operand and its zero test (combinational)
//   flag_z/c/n            registered ALU flags
//   wb_valid              register write committed this cycle
//   hazard                RAW stall indicator
module spu_datapath_pipe #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16,
    parameter int IMM_W = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    rp_addr,
    input  logic [AW-1:0]    rq_addr,
    input  logic [AW-1:0]    w_addr,
    input  logic             w_en,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       alu_op,
    input  logic [IMM_W-1:0] imm,
    input  logic             imm_sext,
    input  logic [WIDTH-1:0] dm_r_data,
    output logic [WIDTH-1:0] dm_w_data,
    output logic             rp_zero,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             wb_valid,
    output logic             hazard
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic             r_st_valid;
    logic [AW-1:0]    r_st_addr;
    logic [WIDTH-1:0] r_st_data;
    logic             r_flag_z;
    logic             r_flag_c;
    logic             r_flag_n;

    logic [WIDTH-1:0] w_rp;
    logic [WIDTH-1:0] w_rq;
    logic [SW-1:0]    w_sh;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_wb_data;
    logic             w_issue;

`ifdef SPU_DP_BYPASS_EN
    // Pending stage write is forwarded so dependent ops issue back-to-back.
    assign w_rp     = (r_st_valid && (r_st_addr == rp_addr)) ? r_st_data : r_regs[rp_addr];
    assign w_rq     = (r_st_valid && (r_st_addr == rq_addr)) ? r_st_data : r_regs[rq_addr];
    assign hazard   = 1'b0;
    assign in_ready = 1'b1;
`else
    // Stage valid already implies the op had w_en; stall until the write lands.
    assign w_rp     = r_regs[rp_addr];
    assign w_rq     = r_regs[rq_addr];
    assign hazard   = r_st_valid && ((r_st_addr == rp_addr) || (r_st_addr == rq_addr));
    assign in_ready = ~hazard;
`endif

    assign w_issue   = in_valid & in_ready;
    assign w_sh      = w_rq[SW-1:0];
    assign dm_w_data = w_rp;
    assign rp_zero   = (w_rp == '0);
    assign wb_valid  = r_st_valid;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign flag_n    = r_flag_n;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (alu_op)
            3'd0: w_res = w_rp;
            3'd1: {w_c, w_res} = {1'b0, w_rp} + {1'b0, w_rq};
            3'd2: begin
                w_res = w_rp - w_rq;
                w_c   = (w_rp < w_rq);
            end
            3'd3: w_res = w_rp & w_rq;
            3'd4: w_res = w_rp | w_rq;
            3'd5: w_res = w_rp ^ w_rq;
            // The extra bit above/below the operand catches the last bit shifted out;
            // a zero shift leaves it at 0.
            3'd6: {w_c, w_res} = {1'b0, w_rp} << w_sh;
            3'd7: {w_res, w_c} = {w_rp, 1'b0} >> w_sh;
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_imm_ext              = {WIDTH{imm_sext & imm[IMM_W-1]}};
        w_imm_ext[IMM_W-1:0]   = imm;
    end

    always_comb begin
        w_wb_data = '0;
        case (wb_sel)
            2'd0: w_wb_data = w_res;
            2'd1: w_wb_data = dm_r_data;
            2'd2: w_wb_data = w_imm_ext;
            default: w_wb_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_st_valid <= 1'b0;
            r_st_addr  <= '0;
            r_st_data  <= '0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_n   <= 1'b0;
        end else begin
            if (r_st_valid) begin
                r_regs[r_st_addr] <= r_st_data;
            end
            r_st_valid <= w_issue & w_en;
            if (w_issue) begin
                r_st_addr <= w_addr;
                r_st_data <= w_wb_data;
            end
            if (w_issue && (wb_sel == 2'd0)) begin
                r_flag_z <= (w_res == '0);
                r_flag_c <= w_c;
                r_flag_n <= w_res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_spu_datapath_pipe.sv
// tb/tb_spu_datapath_pipe.sv - scoreboard bench for spu_datapath_pipe with an architectural reference model
module tb_spu_datapath_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  rp_addr = '0;
    logic [3:0]  rq_addr = '0;
    logic [3:0]  w_addr = '0;
    logic        w_en = 1'b0;
    logic [1:0]  wb_sel = '0;
    logic [2:0]  alu_op = '0;
    logic [7:0]  imm = '0;
    logic        imm_sext = 1'b0;
    logic [15:0] dm_r_data = '0;
    logic [15:0] dm_w_data;
    logic        rp_zero;
    logic        flag_z, flag_c, flag_n;
    logic        wb_valid;
    logic        hazard;

    always #5 clk = ~clk;

    spu_datapath_pipe #(.WIDTH(16), .NREGS(16), .IMM_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rp_addr(rp_addr), .rq_addr(rq_addr), .w_addr(w_addr), .w_en(w_en),
        .wb_sel(wb_sel), .alu_op(alu_op), .imm(imm), .imm_sext(imm_sext),
        .dm_r_data(dm_r_data), .dm_w_data(dm_w_data), .rp_zero(rp_zero),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
        .wb_valid(wb_valid), .hazard(hazard)
    );

    typedef struct {
        bit          chk_rp;
        logic [15:0] rp;
        logic        rdy;
        logic        hz;
        logic        wbv;
        logic [2:0]  fl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Architectural model: committed register file, the one write in flight, flags.
    logic [15:0] mreg [16];
    bit          pw_v;
    int          pw_a;
    logic [15:0] pw_d;
    logic [2:0]  mfl;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
        pw_v = 0;
        pw_a = 0;
        pw_d = 16'h0;
        mfl  = 3'b000;
    endtask

    task automatic drive_op(input int rp, input int rq, input int wa, input int we, input int sel,
                            input int op, input int im, input int sx, input int dm,
                            input int use_c, input int cval);
        bit   done;
        bit   stall;
        bit   c;
        int   a, b, r, sh;
        logic [15:0] wd;
        exp_t e;
        done = 0;
        while (!done) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            rp_addr   = 4'(rp);
            rq_addr   = 4'(rq);
            w_addr    = 4'(wa);
            w_en      = (we != 0);
            wb_sel    = 2'(sel);
            alu_op    = 3'(op);
            imm       = 8'(im);
            imm_sext  = (sx != 0);
            dm_r_data = 16'(dm);
`ifdef SPU_DP_BYPASS_EN
            stall = 0;
            a = (pw_v && pw_a == rp) ? int'(pw_d) : int'(mreg[rp]);
            b = (pw_v && pw_a == rq) ? int'(pw_d) : int'(mreg[rq]);
`else
            stall = pw_v && (pw_a == rp || pw_a == rq);
            a = int'(mreg[rp]);
            b = int'(mreg[rq]);
`endif
            e.chk_rp = !stall;
            e.rp     = (use_c != 0) ? 16'(cval) : 16'(a);
            e.rdy    = !stall;
            e.hz     = stall;
            e.wbv    = pw_v;
            e.fl     = mfl;
            sb.push_back(e);
            if (pw_v) mreg[pw_a] = pw_d;
            pw_v = 0;
            if (!stall) begin
                sh = b % 16;
                c  = 0;
                case (op)
                    0: r = a;
                    1: begin r = (a + b) % 65536; c = (a + b) > 65535; end
                    2: begin r = (a - b + 65536) % 65536; c = a < b; end
                    3: r = a & b;
                    4: r = a | b;
                    5: r = a ^ b;
                    6: begin r = (a << sh) % 65536; c = (((a << sh) >> 16) % 2) != 0; end
                    default: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) % 2) != 0); end
                endcase
                case (sel)
                    0: wd = 16'(r);
                    1: wd = 16'(dm);
                    2: wd = (sx != 0 && (im % 256) >= 128) ? 16'((im % 256) + 16'hFF00) : 16'(im % 256);
                    default: wd = 16'h0;
                endcase
                if (we != 0) begin
                    pw_v = 1;
                    pw_a = wa;
                    pw_d = wd;
                end
                if (sel == 0) mfl = {r == 0, c, r >= 32768};
                done = 1;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (pw_v) mreg[pw_a] = pw_d;
        pw_v = 0;
    endtask

    task automatic ld(input int wa, input int im, input int sx);
        drive_op(0, 0, wa, 1, 2, 0, im, sx, 0, 0, 0);
    endtask

    task automatic alu(input int wa, input int rp, input int rq, input int op);
        drive_op(rp, rq, wa, 1, 0, op, 0, 0, 0, 0, 0);
    endtask

    // Non-writing op with wb_sel=3 so the flags are left untouched.
    task automatic check_reg(input int ra, input int v);
        drive_op(ra, ra, 0, 0, 3, 0, 0, 0, 0, 1, v);
    endtask

    task automatic check_flags(input string nm, input logic [2:0] f);
        idle();
        chk(nm, 32'({flag_z, flag_c, flag_n}), 32'(f));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && in_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_underflow: actual empty required entry at %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("in_ready", 32'(in_ready), 32'(mon_e.rdy));
                    chk("hazard", 32'(hazard), 32'(mon_e.hz));
                    chk("wb_valid", 32'(wb_valid), 32'(mon_e.wbv));
                    chk("flags_zcn", 32'({flag_z, flag_c, flag_n}), 32'(mon_e.fl));
                    if (mon_e.chk_rp) begin
                        chk("dm_w_data", 32'(dm_w_data), 32'(mon_e.rp));
                        chk("rp_zero", 32'(rp_zero), 32'(mon_e.rp == 16'h0));
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);

        ld(1, 8'hF0, 1);
        check_reg(1, 16'hFFF0);
        ld(1, 8'hF0, 0);
        check_reg(1, 16'h00F0);

        ld(1, 5, 0);
        ld(2, 7, 0);
        alu(3, 1, 2, 1);
        alu(4, 3, 3, 1);
        check_reg(4, 24);

        ld(1, 8'hFF, 1);
        ld(2, 1, 0);
        alu(5, 1, 2, 1);
        check_flags("flags_add_wrap", 3'b110);
        ld(6, 3, 0);
        ld(7, 5, 0);
        alu(8, 6, 7, 2);
        check_flags("flags_sub_borrow", 3'b011);
        check_reg(8, 16'hFFFE);
        drive_op(0, 0, 9, 1, 1, 0, 0, 0, 16'h1234, 0, 0);
        check_flags("flags_hold_dm", 3'b011);

        ld(1, 8'h80, 0);
        ld(2, 8, 0);
        alu(1, 1, 2, 6);
        ld(3, 1, 0);
        alu(1, 1, 3, 4);
        check_reg(1, 16'h8001);
        ld(2, 1, 0);
        alu(5, 1, 2, 6);
        check_flags("flags_shl", 3'b010);
        check_reg(5, 16'h0002);
        alu(6, 1, 2, 7);
        check_flags("flags_shr", 3'b010);
        check_reg(6, 16'h4000);
        ld(10, 0, 0);
        alu(11, 1, 10, 6);
        check_flags("flags_shift0", 3'b001);

        drive_op(0, 0, 12, 1, 1, 0, 0, 0, 16'hBEEF, 0, 0);
        check_reg(12, 16'hBEEF);
        drive_op(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        check_reg(0, 0);

        // Reset while the write to r3 sits in the stage: it must never land.
        ld(3, 8'h55, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst2_in_ready", 32'(in_ready), 32'd1);
        chk("rst2_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst2_flags", 32'({flag_z, flag_c, flag_n}), 32'd0);
        check_reg(3, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(9) == 0) begin
                idle();
            end else begin
                drive_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)),
                         int'($urandom_range(3) != 0), int'($urandom_range(3)), int'($urandom_range(7)),
                         int'($urandom_range(255)), int'($urandom_range(1)), int'($urandom_range(65535)),
                         0, 0);
            end
        end

        for (int i = 0; i < 16; i++) begin
            drive_op(i, i, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        end
        idle();
        idle();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
